// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the sequenced reset controller.
package rst_seq_pkg;

   typedef enum logic [1:0] {ASSERT, STRETCH, RELEASE, DONE} state_t;

   // One counter serves both the stretch and the inter-channel gap, so size it for the larger.
   function automatic int cnt_width(input int min_assert, input int step_gap);
      int m;
      m = (min_assert > step_gap) ? min_assert : step_gap;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Single-source reset synchroniser; controller reset forces the request asserted.
module rst_sync_cell #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_DEPTH-1:0] stage;

   always_ff @(posedge clk) begin
      if (rst) stage <= '0;
      else     stage <= {stage[SYNC_DEPTH-2:0], async_in};
   end

   assign sync_out = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Combines NCH async reset sources plus a software reset, stretches the result,
// then releases the downstream active-low resets one channel at a time.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NCH        = 3,
   parameter int SYNC_DEPTH = 2,
   parameter int MIN_ASSERT = 4,
   parameter int STEP_GAP   = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] ext_rstz,
   input  logic           sw_rst,
   output logic [NCH-1:0] srstz,
   output logic           rst_done,
   output logic [NCH:0]   rst_cause
);

   localparam int CW = cnt_width(MIN_ASSERT, STEP_GAP);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] STRETCH_LOAD = CW'(MIN_ASSERT - 1);
   localparam logic [CW-1:0] GAP_LOAD     = CW'(STEP_GAP - 1);
   localparam logic [IW-1:0] LAST_IDX     = IW'(NCH - 1);

   logic [NCH-1:0] sync_ext;
   logic           req;

   for (genvar i = 0; i < NCH; i++) begin : g_sync
      rst_sync_cell #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
         .clk      (clk),
         .rst      (rst),
         .async_in (ext_rstz[i]),
         .sync_out (sync_ext[i])
      );
   end

   assign req = ~(&sync_ext) | sw_rst;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [IW-1:0]  idx, idx_nx;
   logic [NCH-1:0] srstz_nx;
   logic           done_nx;
   logic [NCH:0]   cause_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      srstz_nx = srstz;
      done_nx  = rst_done;
      cause_nx = rst_cause;
      // A new request anywhere past ASSERT aborts the sequence, including a partial release.
      if (req && state != ASSERT) begin
         state_nx = ASSERT;
         cnt_nx   = '0;
         idx_nx   = '0;
         srstz_nx = '0;
         done_nx  = 1'b0;
         cause_nx = {sw_rst, ~sync_ext};
      end else begin
         case (state)
            ASSERT: begin
               srstz_nx = '0;
               done_nx  = 1'b0;
               cause_nx = rst_cause | {sw_rst, ~sync_ext};
               if (!req) begin
                  state_nx = STRETCH;
                  cnt_nx   = STRETCH_LOAD;
               end
            end
            STRETCH: begin
               cause_nx = rst_cause | {sw_rst, ~sync_ext};
               if (cnt == '0) begin
                  state_nx = RELEASE;
                  idx_nx   = '0;
                  cnt_nx   = GAP_LOAD;
                  srstz_nx = NCH'(1);
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            RELEASE: begin
               // Releases are strictly ordered, so srstz is a thermometer: shift in a one.
               if (idx == LAST_IDX) begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
               end else if (cnt == '0) begin
                  idx_nx   = idx + 1'b1;
                  cnt_nx   = GAP_LOAD;
                  srstz_nx = (srstz << 1) | NCH'(1);
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            DONE: ;
            default: state_nx = ASSERT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ASSERT;
         cnt       <= '0;
         idx       <= '0;
         srstz     <= '0;
         rst_done  <= 1'b0;
         rst_cause <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         srstz     <= srstz_nx;
         rst_done  <= done_nx;
         rst_cause <= cause_nx;
      end
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed scoreboard bench: expected output snapshots are queued with the edge
// they belong to, then popped and compared on the falling edge after that edge.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] ext0;
   logic       sw0;
   logic [2:0] srstz0;
   logic       done0;
   logic [3:0] cause0;
   logic [0:0] ext1;
   logic       sw1;
   logic [0:0] srstz1;
   logic       done1;
   logic [1:0] cause1;

   always #5 clk = ~clk;

   rst_seq_ctrl u_dut0 (
      .clk(clk), .rst(rst), .ext_rstz(ext0), .sw_rst(sw0),
      .srstz(srstz0), .rst_done(done0), .rst_cause(cause0)
   );

   rst_seq_ctrl #(.NCH(1), .SYNC_DEPTH(3), .MIN_ASSERT(1), .STEP_GAP(3)) u_dut1 (
      .clk(clk), .rst(rst), .ext_rstz(ext1), .sw_rst(sw1),
      .srstz(srstz1), .rst_done(done1), .rst_cause(cause1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int order_viol = 0;

   // Outputs must always form a thermometer: a later channel never released ahead of an earlier one.
   always @(negedge clk)
      if ((srstz0[1] & ~srstz0[0]) | (srstz0[2] & ~srstz0[1])) order_viol = order_viol + 1;

   typedef struct {
      int         at;
      int         u;
      logic [2:0] s;
      logic       d;
      logic       chk_c;
      logic [3:0] c;
      string      tag;
   } exp_t;

   exp_t sb[$];

   task automatic push(input int at, input int u, input logic [2:0] s, input logic d,
                       input logic cc, input logic [3:0] c, input string tag);
      exp_t e;
      e.at = at; e.u = u; e.s = s; e.d = d; e.chk_c = cc; e.c = c; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s got %b want %b", tag, act, exp);
      end
   endtask

   // Full release sequence of the 3-channel instance around release edge r.
   task automatic seq_exp(input int r, input logic [3:0] cause, input string tag);
      push(r - 1, 0, 3'b000, 1'b0, 1'b0, 4'b0, {tag, " pre"});
      push(r,     0, 3'b001, 1'b0, 1'b0, 4'b0, {tag, " ch0"});
      push(r + 2, 0, 3'b001, 1'b0, 1'b0, 4'b0, {tag, " gap0"});
      push(r + 3, 0, 3'b011, 1'b0, 1'b0, 4'b0, {tag, " ch1"});
      push(r + 5, 0, 3'b011, 1'b0, 1'b0, 4'b0, {tag, " gap1"});
      push(r + 6, 0, 3'b111, 1'b0, 1'b0, 4'b0, {tag, " ch2"});
      push(r + 7, 0, 3'b111, 1'b1, 1'b1, cause, {tag, " done"});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         while (cyc < e.at) @(negedge clk);
         checks++;
         assert (cyc == e.at) else begin
            errors++;
            $error("FAIL %s edge got %0d want %0d", e.tag, cyc, e.at);
         end
         if (e.u == 0) begin
            chk({e.tag, " srstz"}, {1'b0, srstz0}, {1'b0, e.s});
            chk({e.tag, " done"}, {3'b0, done0}, {3'b0, e.d});
            if (e.chk_c) chk({e.tag, " cause"}, cause0, e.c);
         end else begin
            chk({e.tag, " srstz"}, {3'b0, srstz1}, {1'b0, e.s});
            chk({e.tag, " done"}, {3'b0, done1}, {3'b0, e.d});
            if (e.chk_c) chk({e.tag, " cause"}, {2'b0, cause1}, e.c);
         end
      end
   endtask

   initial begin
      int e0, n, s, r;
      rst = 1'b1; ext0 = 3'b111; sw0 = 1'b0; ext1 = 1'b1; sw1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst srstz", {1'b0, srstz0}, 4'b0000);
      chk("rst done", {3'b0, done0}, 4'b0000);
      chk("rst cause", cause0, 4'b0000);
      chk("rst srstz1", {3'b0, srstz1}, 4'b0000);

      // Release from controller reset; sync stages start at 0, so cause records all sources.
      rst = 1'b0;
      e0 = cyc + 1;
      push(e0 + 3, 1, 3'b000, 1'b0, 1'b0, 4'b0, "n1 pre");
      push(e0 + 4, 1, 3'b001, 1'b0, 1'b0, 4'b0, "n1 ch0");
      push(e0 + 5, 1, 3'b001, 1'b1, 1'b1, 4'b0001, "n1 done");
      seq_exp(e0 + 6, 4'b0111, "por");
      drain();

      // All external sources asserted while DONE, then released together.
      ext0 = 3'b000; n = cyc;
      push(n + 2, 0, 3'b111, 1'b1, 1'b0, 4'b0, "all lag");
      push(n + 3, 0, 3'b000, 1'b0, 1'b1, 4'b0111, "all abort");
      drain();
      repeat (2) @(negedge clk);
      ext0 = 3'b111; e0 = cyc + 1;
      seq_exp(e0 + 6, 4'b0111, "all");
      drain();

      // Single source bit 1 low for three cycles.
      ext0 = 3'b101; n = cyc;
      push(n + 2, 0, 3'b111, 1'b1, 1'b0, 4'b0, "b1 lag");
      push(n + 3, 0, 3'b000, 1'b0, 1'b1, 4'b0010, "b1 abort");
      drain();
      ext0 = 3'b111; e0 = cyc + 1;
      seq_exp(e0 + 6, 4'b0010, "b1");
      drain();

      // Software reset pulse while stretching with cnt == 1 restarts the full stretch.
      ext0 = 3'b000; n = cyc;
      push(n + 3, 0, 3'b000, 1'b0, 1'b1, 4'b0111, "st abort");
      drain();
      ext0 = 3'b111; e0 = cyc + 1;
      push(e0 + 4, 0, 3'b000, 1'b0, 1'b0, 4'b0, "st cnt1");
      drain();
      sw0 = 1'b1;
      @(negedge clk);
      sw0 = 1'b0; s = cyc;
      push(s, 0, 3'b000, 1'b0, 1'b1, 4'b1000, "st sw");
      seq_exp(s + 5, 4'b1000, "st");
      drain();

      // Software reset pulse during RELEASE, just after channel 0 came out.
      sw0 = 1'b1; n = cyc;
      @(negedge clk);
      sw0 = 1'b0;
      push(n + 1, 0, 3'b000, 1'b0, 1'b1, 4'b1000, "rl sw0");
      r = n + 6;
      push(r, 0, 3'b001, 1'b0, 1'b0, 4'b0, "rl ch0");
      drain();
      sw0 = 1'b1;
      @(negedge clk);
      sw0 = 1'b0;
      push(r + 1, 0, 3'b000, 1'b0, 1'b1, 4'b1000, "rl abort");
      seq_exp(r + 6, 4'b1000, "rl");
      drain();

      checks++;
      assert (order_viol == 0) else begin
         errors++;
         $error("FAIL order violations got %0d want 0", order_viol);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
